// File: rtl/sdrc_mport_pkg.sv
// Shared types and helpers for the multi-port SDRAM request arbiter.
package sdrc_mport_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } arb_state_t;

    // Channel index width; a single channel still needs a 1-bit tag.
    function automatic int chw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Low bit of channel idx inside a packed per-channel bus of field width w.
    function automatic int field_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/sdrc_mport_arb_if.sv
// Request/data handshake between the arbiter (master) and sdrc_core (slave).
interface sdrc_mport_arb_if #(
    parameter int APP_AW = 26,
    parameter int APP_DW = 32,
    parameter int APP_BW = 4,
    parameter int BL     = 9
);
    logic              app_req;
    logic [APP_AW-1:0] app_req_addr;
    logic [BL-1:0]     app_req_len;
    logic              app_req_wr_n;
    logic              app_req_ack;
    logic [APP_DW-1:0] app_wr_data;
    logic [APP_BW-1:0] app_wr_en_n;
    logic              app_wr_next_req;
    logic              app_last_wr;
    logic              app_rd_valid;
    logic              app_last_rd;
    logic [APP_DW-1:0] app_rd_data;

    modport master (
        output app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_data, app_wr_en_n,
        input  app_req_ack, app_wr_next_req, app_last_wr, app_rd_valid, app_last_rd, app_rd_data
    );

    modport slave (
        input  app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_data, app_wr_en_n,
        output app_req_ack, app_wr_next_req, app_last_wr, app_rd_valid, app_last_rd, app_rd_data
    );
endinterface

// File: rtl/sdrc_owner_fifo.sv
// In-order FIFO of channel tags recording which channel owns each outstanding burst.
module sdrc_owner_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     sdram_clk,
    input  logic                     sdram_resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge sdram_clk) begin
        if (push_ok)
            mem_reg[wr_ptr_reg] <= push_data;
    end

    // Pointers wrap naturally at DEPTH; the extra count bit separates full from empty.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/sdrc_mport_arb.sv
// N-channel round-robin / fixed-priority front-end for sdrc_core with
// in-order write/read data steering via two owner-tag FIFOs.
module sdrc_mport_arb
    import sdrc_mport_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int APP_AW    = 26,
    parameter int APP_DW    = 32,
    parameter int APP_BW    = 4,
    parameter int BL        = 9,
    parameter int TAG_DEPTH = 4
) (
    input  logic                  sdram_clk,
    input  logic                  sdram_resetn,
    input  logic                  sdr_init_done,
    input  logic                  cfg_prio_mode,
    input  logic [NCH-1:0]        ch_req,
    input  logic [NCH*APP_AW-1:0] ch_req_addr,
    input  logic [NCH*BL-1:0]     ch_req_len,
    input  logic [NCH-1:0]        ch_req_wr_n,
    output logic [NCH-1:0]        ch_req_ack,
    input  logic [NCH*APP_DW-1:0] ch_wr_data,
    input  logic [NCH*APP_BW-1:0] ch_wr_en_n,
    output logic [NCH-1:0]        ch_wr_next,
    output logic [APP_DW-1:0]     ch_rd_data,
    output logic [NCH-1:0]        ch_rd_valid,
    output logic [NCH-1:0]        ch_last_rd,
    sdrc_mport_arb_if.master      app,
    output logic                  err_orphan
);
    localparam int CHW = chw_of(NCH);
    localparam int CW  = $clog2(TAG_DEPTH) + 1;

    logic [APP_AW-1:0] addr_arr  [NCH];
    logic [BL-1:0]     len_arr   [NCH];
    logic [APP_DW-1:0] wdata_arr [NCH];
    logic [APP_BW-1:0] wen_arr   [NCH];
    logic [NCH-1:0]    eligible;

    arb_state_t        state_reg;
    logic [CHW-1:0]    grant_reg;
    logic [CHW-1:0]    rr_ptr_reg;
    logic [APP_AW-1:0] addr_reg;
    logic [BL-1:0]     len_reg;
    logic              wr_n_reg;
    logic              err_orphan_reg;

    logic              wr_full, wr_empty, rd_full, rd_empty;
    logic [CW-1:0]     wr_count, rd_count;
    logic [CHW-1:0]    wr_head, rd_head;
    logic              ack_fire, wr_pop, rd_pop;

    logic [2*NCH-1:0]  elig_shift;
    logic [NCH-1:0]    pick_vec;
    logic              pick_found;
    logic [CHW-1:0]    pick_off;
    logic [CHW:0]      pick_sum;
    logic [CHW-1:0]    pick_idx;

    assign ack_fire = (state_reg == REQ) & app.app_req_ack;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        assign addr_arr[gi]    = ch_req_addr[field_lo(gi, APP_AW) +: APP_AW];
        assign len_arr[gi]     = ch_req_len[field_lo(gi, BL) +: BL];
        assign wdata_arr[gi]   = ch_wr_data[field_lo(gi, APP_DW) +: APP_DW];
        assign wen_arr[gi]     = ch_wr_en_n[field_lo(gi, APP_BW) +: APP_BW];
        assign eligible[gi]    = ch_req[gi] & (ch_req_wr_n[gi] ? ~rd_full : ~wr_full);
        assign ch_req_ack[gi]  = ack_fire & (grant_reg == CHW'(gi));
        assign ch_wr_next[gi]  = ~wr_empty & (wr_head == CHW'(gi)) & app.app_wr_next_req;
        assign ch_rd_valid[gi] = ~rd_empty & (rd_head == CHW'(gi)) & app.app_rd_valid;
        assign ch_last_rd[gi]  = ~rd_empty & (rd_head == CHW'(gi)) & app.app_rd_valid & app.app_last_rd;
    end

    // Round-robin searches a copy of the eligible mask rotated down by rr_ptr,
    // then adds rr_ptr back (mod NCH) to recover the channel index.
    assign elig_shift = {eligible, eligible} >> rr_ptr_reg;

    always_comb begin
        pick_vec   = cfg_prio_mode ? eligible : elig_shift[NCH-1:0];
        pick_found = 1'b0;
        pick_off   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (pick_vec[k]) begin
                pick_found = 1'b1;
                pick_off   = CHW'(k);
            end
        end
        pick_sum = {1'b0, pick_off} + (cfg_prio_mode ? '0 : {1'b0, rr_ptr_reg});
        if (pick_sum >= (CHW+1)'(NCH))
            pick_sum = pick_sum - (CHW+1)'(NCH);
        pick_idx = pick_sum[CHW-1:0];
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
            addr_reg   <= '0;
            len_reg    <= '0;
            wr_n_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sdr_init_done && pick_found) begin
                        grant_reg <= pick_idx;
                        addr_reg  <= addr_arr[pick_idx];
                        len_reg   <= len_arr[pick_idx];
                        wr_n_reg  <= ch_req_wr_n[pick_idx];
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (app.app_req_ack) begin
                        rr_ptr_reg <= (grant_reg == CHW'(NCH - 1)) ? '0 : grant_reg + 1'b1;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // A data beat with no recorded owner means the core and this block disagree.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn)
            err_orphan_reg <= 1'b0;
        else if ((app.app_wr_next_req && wr_count == '0) || (app.app_rd_valid && rd_count == '0))
            err_orphan_reg <= 1'b1;
    end

    assign wr_pop = app.app_wr_next_req & app.app_last_wr;
    assign rd_pop = app.app_rd_valid & app.app_last_rd;

    sdrc_owner_fifo #(.WIDTH(CHW), .DEPTH(TAG_DEPTH)) u_wr_fifo (
        .sdram_clk    (sdram_clk),
        .sdram_resetn (sdram_resetn),
        .push         (ack_fire & ~wr_n_reg),
        .push_data    (grant_reg),
        .pop          (wr_pop),
        .head         (wr_head),
        .full         (wr_full),
        .empty        (wr_empty),
        .count        (wr_count)
    );

    sdrc_owner_fifo #(.WIDTH(CHW), .DEPTH(TAG_DEPTH)) u_rd_fifo (
        .sdram_clk    (sdram_clk),
        .sdram_resetn (sdram_resetn),
        .push         (ack_fire & wr_n_reg),
        .push_data    (grant_reg),
        .pop          (rd_pop),
        .head         (rd_head),
        .full         (rd_full),
        .empty        (rd_empty),
        .count        (rd_count)
    );

    assign app.app_req      = (state_reg == REQ);
    assign app.app_req_addr = addr_reg;
    assign app.app_req_len  = len_reg;
    assign app.app_req_wr_n = wr_n_reg;
    assign app.app_wr_data  = wdata_arr[wr_head];
    assign app.app_wr_en_n  = wr_empty ? '1 : wen_arr[wr_head];
    assign ch_rd_data       = app.app_rd_data;
    assign err_orphan       = err_orphan_reg;

endmodule

// File: tb/tb_sdrc_mport_arb.sv
// Directed bench for sdrc_mport_arb: arbitration order, data steering, FIFO full, orphan, reset.
module tb_sdrc_mport_arb;
    localparam int NCH = 4, APP_AW = 26, APP_DW = 32, APP_BW = 4, BL = 9, TAG_DEPTH = 4;

    logic                  sdram_clk = 1'b0;
    logic                  sdram_resetn = 1'b0;
    logic                  sdr_init_done = 1'b0;
    logic                  cfg_prio_mode = 1'b0;
    logic [NCH-1:0]        ch_req = '0;
    logic [NCH-1:0]        ch_req_wr_n = '1;
    logic [NCH*APP_AW-1:0] ch_req_addr;
    logic [NCH*BL-1:0]     ch_req_len;
    logic [NCH*APP_DW-1:0] ch_wr_data;
    logic [NCH*APP_BW-1:0] ch_wr_en_n;
    logic [NCH-1:0]        ch_req_ack, ch_wr_next, ch_rd_valid, ch_last_rd;
    logic [APP_DW-1:0]     ch_rd_data;
    logic                  err_orphan;

    logic [APP_AW-1:0] s_addr  [NCH];
    logic [BL-1:0]     s_len   [NCH];
    logic [APP_DW-1:0] s_wdata [NCH];
    logic [APP_BW-1:0] s_wen   [NCH];

    int n_checks = 0;
    int n_pass   = 0;

    sdrc_mport_arb_if #(.APP_AW(APP_AW), .APP_DW(APP_DW), .APP_BW(APP_BW), .BL(BL)) app_bus ();

    sdrc_mport_arb #(
        .NCH(NCH), .APP_AW(APP_AW), .APP_DW(APP_DW), .APP_BW(APP_BW), .BL(BL), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .sdram_clk     (sdram_clk),
        .sdram_resetn  (sdram_resetn),
        .sdr_init_done (sdr_init_done),
        .cfg_prio_mode (cfg_prio_mode),
        .ch_req        (ch_req),
        .ch_req_addr   (ch_req_addr),
        .ch_req_len    (ch_req_len),
        .ch_req_wr_n   (ch_req_wr_n),
        .ch_req_ack    (ch_req_ack),
        .ch_wr_data    (ch_wr_data),
        .ch_wr_en_n    (ch_wr_en_n),
        .ch_wr_next    (ch_wr_next),
        .ch_rd_data    (ch_rd_data),
        .ch_rd_valid   (ch_rd_valid),
        .ch_last_rd    (ch_last_rd),
        .app           (app_bus),
        .err_orphan    (err_orphan)
    );

    always #5 sdram_clk = ~sdram_clk;

    always_comb begin
        ch_req_addr = '0;
        ch_req_len  = '0;
        ch_wr_data  = '0;
        ch_wr_en_n  = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_req_addr[i*APP_AW +: APP_AW] = s_addr[i];
            ch_req_len[i*BL +: BL]          = s_len[i];
            ch_wr_data[i*APP_DW +: APP_DW]  = s_wdata[i];
            ch_wr_en_n[i*APP_BW +: APP_BW]  = s_wen[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [NCH-1:0] onehot(input int i);
        logic [NCH-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic apply_reset();
        sdram_resetn  = 1'b0;
        sdr_init_done = 1'b1;
        cfg_prio_mode = 1'b0;
        ch_req        = '0;
        ch_req_wr_n   = '1;
        app_bus.app_req_ack     = 1'b0;
        app_bus.app_wr_next_req = 1'b0;
        app_bus.app_last_wr     = 1'b0;
        app_bus.app_rd_valid    = 1'b0;
        app_bus.app_last_rd     = 1'b0;
        app_bus.app_rd_data     = '0;
        repeat (2) @(negedge sdram_clk);
        #1;
        check("rst_app_req", app_bus.app_req, 1'b0);
        check("rst_addr", app_bus.app_req_addr, '0);
        check("rst_len", app_bus.app_req_len, '0);
        check("rst_wr_n", app_bus.app_req_wr_n, 1'b0);
        check("rst_ack", ch_req_ack, '0);
        check("rst_wr_next", ch_wr_next, '0);
        check("rst_rd_valid", ch_rd_valid, '0);
        check("rst_last_rd", ch_last_rd, '0);
        check("rst_orphan", err_orphan, 1'b0);
        check("rst_wr_en_n", app_bus.app_wr_en_n, 4'hF);
        @(negedge sdram_clk);
        sdram_resetn = 1'b1;
    endtask

    // Wait (bounded) for app_req, verify fields, ack it, and change ch_req to next_req on the ack.
    task automatic do_grant(input int g, input logic [NCH-1:0] next_req, input string tag);
        for (int w = 0; w < 12 && app_bus.app_req !== 1'b1; w++)
            @(negedge sdram_clk);
        check({tag, "_req_seen"}, app_bus.app_req, 1'b1);
        if (app_bus.app_req !== 1'b1)
            return;
        check({tag, "_addr"}, app_bus.app_req_addr, s_addr[g]);
        check({tag, "_len"}, app_bus.app_req_len, s_len[g]);
        check({tag, "_wr_n"}, app_bus.app_req_wr_n, ch_req_wr_n[g]);
        app_bus.app_req_ack = 1'b1;
        ch_req = next_req;
        #1;
        check({tag, "_ack"}, ch_req_ack, onehot(g));
        $display("grant ch%0d addr=0x%0h len=%0d wr_n=%0b", g, app_bus.app_req_addr,
                 app_bus.app_req_len, app_bus.app_req_wr_n);
        @(negedge sdram_clk);
        app_bus.app_req_ack = 1'b0;
        #1;
        check({tag, "_ack_pulse"}, ch_req_ack, '0);
        check({tag, "_req_drop"}, app_bus.app_req, 1'b0);
    endtask

    task automatic rd_beat(input string tag, input logic [NCH-1:0] owner, input logic last,
                           input logic [APP_DW-1:0] data);
        app_bus.app_rd_valid = 1'b1;
        app_bus.app_last_rd  = last;
        app_bus.app_rd_data  = data;
        #1;
        check({tag, "_valid"}, ch_rd_valid, owner);
        check({tag, "_last"}, ch_last_rd, last ? owner : '0);
        check({tag, "_data"}, ch_rd_data, data);
        $display("rd beat data=0x%0h valid=%b last=%b", data, ch_rd_valid, ch_last_rd);
        @(negedge sdram_clk);
        app_bus.app_rd_valid = 1'b0;
        app_bus.app_last_rd  = 1'b0;
    endtask

    task automatic wr_beat(input string tag, input logic [NCH-1:0] owner, input logic last,
                           input logic [APP_DW-1:0] exp_data);
        app_bus.app_wr_next_req = 1'b1;
        app_bus.app_last_wr     = last;
        #1;
        check({tag, "_next"}, ch_wr_next, owner);
        check({tag, "_data"}, app_bus.app_wr_data, exp_data);
        check({tag, "_no_req"}, app_bus.app_req, 1'b0);
        $display("wr beat data=0x%0h next=%b last=%b", app_bus.app_wr_data, ch_wr_next, last);
        @(negedge sdram_clk);
        app_bus.app_wr_next_req = 1'b0;
        app_bus.app_last_wr     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        for (int i = 0; i < NCH; i++) begin
            s_addr[i]  = APP_AW'(32'h1000 * (i + 1) + i);
            s_len[i]   = BL'(4);
            s_wdata[i] = 32'hD000_0000 + i;
            s_wen[i]   = 4'hF;
        end

        // Round-robin, all reading: 0,1,2,3,0
        apply_reset();
        ch_req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            g = k % NCH;
            do_grant(g, (k == 4) ? 4'h0 : 4'hF, "rr");
            rd_beat("rr_rd", onehot(g), 1'b1, 32'h1000 + k);
            if (k < 4) begin
                #1;
                check("rr_latency", app_bus.app_req, 1'b1);
            end
        end

        // Fixed priority: 1 wins while held, then 3
        apply_reset();
        cfg_prio_mode = 1'b1;
        ch_req = 4'b1010;
        do_grant(1, 4'b1010, "fp");
        rd_beat("fp_rd", onehot(1), 1'b1, 32'h2001);
        do_grant(1, 4'b1010, "fp");
        rd_beat("fp_rd", onehot(1), 1'b1, 32'h2002);
        do_grant(1, 4'b1000, "fp");
        rd_beat("fp_rd", onehot(1), 1'b1, 32'h2003);
        do_grant(3, 4'b0000, "fp3");
        rd_beat("fp3_rd", onehot(3), 1'b1, 32'h2004);

        // Read routing: ch2 len 4 then ch0 len 2
        apply_reset();
        s_len[2] = BL'(4);
        s_len[0] = BL'(2);
        ch_req = 4'b0100;
        do_grant(2, 4'b0001, "rt2");
        do_grant(0, 4'b0000, "rt0");
        for (int k = 0; k < 4; k++)
            rd_beat("rt2_rd", onehot(2), k == 3, 32'hA0 + k);
        for (int k = 0; k < 2; k++)
            rd_beat("rt0_rd", onehot(0), k == 1, 32'hB0 + k);

        // Write mux and owner FIFO full
        apply_reset();
        ch_req_wr_n = '0;
        s_wdata[1]  = 32'hCAFE_0001;
        s_wen[1]    = 4'h0;
        s_len[1]    = BL'(2);
        #1;
        check("wr_noowner_en", app_bus.app_wr_en_n, 4'hF);
        ch_req = 4'b0010;
        for (int k = 0; k < 4; k++)
            do_grant(1, 4'b0010, "wr");
        for (int k = 0; k < 4; k++) begin
            @(negedge sdram_clk);
            #1;
            check("wr_full_hold", app_bus.app_req, 1'b0);
        end
        check("wr_mux_data", app_bus.app_wr_data, 32'hCAFE_0001);
        check("wr_mux_en", app_bus.app_wr_en_n, 4'h0);
        wr_beat("wr_b0", onehot(1), 1'b0, 32'hCAFE_0001);
        wr_beat("wr_b1", onehot(1), 1'b1, 32'hCAFE_0001);
        #1;
        check("wr_after_pop", app_bus.app_req, 1'b0);
        do_grant(1, 4'b0000, "wr5");

        // Init gating and orphan
        apply_reset();
        sdr_init_done = 1'b0;
        ch_req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            @(negedge sdram_clk);
            #1;
            check("init_gate", app_bus.app_req, 1'b0);
        end
        check("orphan_pre", err_orphan, 1'b0);
        rd_beat("orphan_rd", 4'b0000, 1'b1, 32'hBAD0);
        #1;
        check("orphan_set", err_orphan, 1'b1);
        repeat (3) @(negedge sdram_clk);
        #1;
        check("orphan_sticky", err_orphan, 1'b1);

        // Async reset while app_req is high
        sdr_init_done = 1'b1;
        for (int w = 0; w < 12 && app_bus.app_req !== 1'b1; w++)
            @(negedge sdram_clk);
        check("init_go", app_bus.app_req, 1'b1);
        #2;
        sdram_resetn = 1'b0;
        #1;
        check("arst_req", app_bus.app_req, 1'b0);
        check("arst_orphan", err_orphan, 1'b0);
        @(negedge sdram_clk);
        ch_req = 4'b1001;
        sdram_resetn = 1'b1;
        do_grant(0, 4'b0000, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
